// File: rtl/urv_irq_ctrl.sv
// Interrupt collector and periodic tick source for the uRV core.
// Synchronises peripheral lines, latches level/edge pending bits and exposes a small register port.
module urv_irq_ctrl #(
    parameter int unsigned g_num_irqs    = 16,
    parameter int unsigned g_timer_width = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [g_num_irqs-1:0] irq_src_i,
    input  logic [2:0]            reg_addr_i,
    input  logic                  reg_wr_i,
    input  logic                  reg_rd_i,
    input  logic [31:0]           reg_wdata_i,
    output logic [31:0]           reg_rdata_o,
    output logic                  reg_ack_o,
    output logic                  irq_o,
    output logic                  tick_o
);

    localparam logic [2:0] AddrPending = 3'd0;
    localparam logic [2:0] AddrMask    = 3'd1;
    localparam logic [2:0] AddrEdge    = 3'd2;
    localparam logic [2:0] AddrVector  = 3'd3;
    localparam logic [2:0] AddrPeriod  = 3'd4;
    localparam logic [2:0] AddrCount   = 3'd5;
    localparam logic [2:0] AddrCtrl    = 3'd6;

    localparam logic [g_timer_width-1:0] TimerOne = g_timer_width'(1);

    logic [g_num_irqs-1:0]    s1_q, s2_q, s3_q;
    logic [g_num_irqs-1:0]    pending_q, pending_d;
    logic [g_num_irqs-1:0]    mask_q, mask_d;
    logic [g_num_irqs-1:0]    edge_cfg_q, edge_cfg_d;
    logic [g_timer_width-1:0] period_q, period_d;
    logic [g_timer_width-1:0] count_q, count_d;
    logic                     ctrl_q, ctrl_d;
    logic                     tick_q, tick_d;
    logic                     irq_q, irq_d;
    logic                     ack_q, ack_d;
    logic [31:0]              rdata_q, rdata_d;

    logic                     wr_en, rd_en;
    logic                     wr_pending, wr_mask, wr_edge, wr_period, wr_ctrl;
    logic [g_num_irqs-1:0]    masked, w1c, edge_chg, rise;
    logic [31:0]              vector, rd_val;

    // A simultaneous read and write is serviced as a write only.
    assign wr_en = reg_wr_i;
    assign rd_en = reg_rd_i & ~reg_wr_i;

    assign wr_pending = wr_en && (reg_addr_i == AddrPending);
    assign wr_mask    = wr_en && (reg_addr_i == AddrMask);
    assign wr_edge    = wr_en && (reg_addr_i == AddrEdge);
    assign wr_period  = wr_en && (reg_addr_i == AddrPeriod);
    assign wr_ctrl    = wr_en && (reg_addr_i == AddrCtrl);

    assign masked   = pending_q & mask_q;
    assign rise     = s2_q & ~s3_q;
    assign w1c      = wr_pending ? reg_wdata_i[g_num_irqs-1:0] : '0;
    assign edge_chg = wr_edge ? (reg_wdata_i[g_num_irqs-1:0] ^ edge_cfg_q) : '0;

    always_comb begin
        vector = '0;
        for (int i = int'(g_num_irqs) - 1; i >= 0; i--) begin
            if (masked[i]) begin
                vector[4:0] = 5'(i);
            end
        end
        vector[31] = |masked;
    end

    always_comb begin
        case (reg_addr_i)
            AddrPending: rd_val = 32'(pending_q);
            AddrMask:    rd_val = 32'(mask_q);
            AddrEdge:    rd_val = 32'(edge_cfg_q);
            AddrVector:  rd_val = vector;
            AddrPeriod:  rd_val = 32'(period_q);
            AddrCount:   rd_val = 32'(count_q);
            AddrCtrl:    rd_val = {31'b0, ctrl_q};
            default:     rd_val = '0;
        endcase
    end

    always_comb begin
        mask_d     = wr_mask ? reg_wdata_i[g_num_irqs-1:0] : mask_q;
        edge_cfg_d = wr_edge ? reg_wdata_i[g_num_irqs-1:0] : edge_cfg_q;
        // Edge bits: a new rising edge beats a W1C; switching mode always clears the bit.
        pending_d  = ((edge_cfg_q & (rise | (pending_q & ~w1c))) | (~edge_cfg_q & s2_q))
                     & ~edge_chg;
        irq_d      = |masked;
        ack_d      = wr_en | rd_en;
        rdata_d    = rd_en ? rd_val : '0;
    end

    always_comb begin
        period_d = period_q;
        ctrl_d   = ctrl_q;
        count_d  = count_q;
        tick_d   = 1'b0;
        if (wr_period) begin
            period_d = reg_wdata_i[g_timer_width-1:0];
        end
        if (wr_ctrl) begin
            ctrl_d = reg_wdata_i[0];
        end
        if (wr_period || (wr_ctrl && reg_wdata_i[0])) begin
            count_d = period_d - TimerOne;
        end else if (ctrl_q && !wr_ctrl && (period_q != '0)) begin
            if (count_q == '0) begin
                tick_d  = 1'b1;
                count_d = period_q - TimerOne;
            end else begin
                count_d = count_q - TimerOne;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            edge_cfg_q <= '0;
            period_q   <= '0;
            count_q    <= '0;
            ctrl_q     <= 1'b0;
            tick_q     <= 1'b0;
            irq_q      <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            s1_q       <= irq_src_i;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            edge_cfg_q <= edge_cfg_d;
            period_q   <= period_d;
            count_q    <= count_d;
            ctrl_q     <= ctrl_d;
            tick_q     <= tick_d;
            irq_q      <= irq_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
        end
    end

    assign reg_rdata_o = rdata_q;
    assign reg_ack_o   = ack_q;
    assign irq_o       = irq_q;
    assign tick_o      = tick_q;

endmodule

// File: tb/tb_urv_irq_ctrl.sv
// Bench for urv_irq_ctrl: directed scenarios with literal expectations plus randomised traffic,
// all outputs compared every cycle against a behavioural model built from source history.
module tb_urv_irq_ctrl;

    localparam int unsigned N = 16;
    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  src;
    logic [2:0]    addr;
    logic          wr, rd;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ack, irq, tick;

    always #5 clk = ~clk;

    urv_irq_ctrl #(
        .g_num_irqs   (N),
        .g_timer_width(W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .irq_src_i  (src),
        .reg_addr_i (addr),
        .reg_wr_i   (wr),
        .reg_rd_i   (rd),
        .reg_wdata_i(wdata),
        .reg_rdata_o(rdata),
        .reg_ack_o  (ack),
        .irq_o      (irq),
        .tick_o     (tick)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: h0/h1/h2 are the raw source values sampled 1, 2 and 3 edges ago.
    logic [N-1:0]  m_h0, m_h1, m_h2;
    logic [N-1:0]  m_pend, m_mask, m_edge;
    logic [W-1:0]  m_period, m_count;
    logic          m_en, m_irq, m_tick, m_ack;
    logic [31:0]   m_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h0 = '0; m_h1 = '0; m_h2 = '0;
        m_pend = '0; m_mask = '0; m_edge = '0;
        m_period = '0; m_count = '0; m_en = 1'b0;
        m_irq = 1'b0; m_tick = 1'b0; m_ack = 1'b0; m_rdata = '0;
    endtask

    function automatic logic [31:0] m_vector();
        for (int i = 0; i < int'(N); i++) begin
            if (m_pend[i] && m_mask[i]) return 32'h8000_0000 | 32'(i);
        end
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_pend);
            3'd1:    return 32'(m_mask);
            3'd2:    return 32'(m_edge);
            3'd3:    return m_vector();
            3'd4:    return 32'(m_period);
            3'd5:    return 32'(m_count);
            3'd6:    return {31'b0, m_en};
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs presented at that edge.
    task automatic model_edge();
        logic          w, r;
        logic [N-1:0]  nxt;
        w = wr;
        r = rd && !wr;
        m_ack   = w || r;
        m_rdata = r ? m_read(addr) : 32'h0;
        m_irq   = |(m_pend & m_mask);
        for (int i = 0; i < int'(N); i++) begin
            if (w && addr == 3'd2 && wdata[i] != m_edge[i]) nxt[i] = 1'b0;
            else if (!m_edge[i]) nxt[i] = m_h1[i];
            else if (m_h1[i] && !m_h2[i]) nxt[i] = 1'b1;
            else if (w && addr == 3'd0 && wdata[i]) nxt[i] = 1'b0;
            else nxt[i] = m_pend[i];
        end
        m_tick = 1'b0;
        if (w && (addr == 3'd4 || (addr == 3'd6 && wdata[0]))) begin
            if (addr == 3'd4) m_period = wdata[W-1:0];
            m_count = m_period - 32'd1;
        end else if (m_en && !(w && addr == 3'd6) && m_period != 0) begin
            if (m_count == 0) begin
                m_tick  = 1'b1;
                m_count = m_period - 32'd1;
            end else begin
                m_count = m_count - 32'd1;
            end
        end
        if (w && addr == 3'd6) m_en = wdata[0];
        if (w && addr == 3'd1) m_mask = wdata[N-1:0];
        if (w && addr == 3'd2) m_edge = wdata[N-1:0];
        m_pend = nxt;
        m_h2 = m_h1;
        m_h1 = m_h0;
        m_h0 = src;
    endtask

    // One clock: model follows the edge, all outputs are compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("irq_o", 32'(irq), 32'(m_irq));
        check("tick_o", 32'(tick), 32'(m_tick));
        check("reg_ack_o", 32'(ack), 32'(m_ack));
        check("reg_rdata_o", rdata, m_rdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        cycle();
        wr = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a, output logic [31:0] d);
        addr = a; rd = 1'b1;
        cycle();
        d = rdata;
        rd = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        do_read(a, d);
        check(name, d, exp);
    endtask

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            src = src ^ N'($urandom & $urandom & $urandom);
            addr = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: begin wr = 1'b0; rd = 1'b0; end
                1: begin wr = 1'b0; rd = 1'b1; end
                2: begin wr = 1'b1; rd = 1'b0; end
                default: begin wr = 1'b1; rd = 1'b1; end
            endcase
            if (addr == 3'd4) wdata = 32'($urandom_range(0, 5));
            else wdata = $urandom;
            cycle();
        end
        wr = 1'b0; rd = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        src = '0; addr = '0; wr = 1'b0; rd = 1'b0; wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        read_expect("rst_pending", 3'd0, 32'h0);
        read_expect("rst_mask", 3'd1, 32'h0);
        read_expect("rst_vector", 3'd3, 32'h0);

        // Level source 3
        do_write(3'd1, 32'h8);
        src[3] = 1'b1;
        idle(3);
        check("lvl_irq_not_yet", 32'(irq), 32'h0);
        cycle();
        check("lvl_irq_high", 32'(irq), 32'h1);
        read_expect("lvl_vector", 3'd3, 32'h8000_0003);
        do_write(3'd0, 32'h8);
        read_expect("lvl_w1c_ignored", 3'd0, 32'h8);
        src[3] = 1'b0;
        idle(3);
        check("lvl_irq_still_high", 32'(irq), 32'h1);
        cycle();
        check("lvl_irq_low", 32'(irq), 32'h0);

        // Edge source 5
        do_write(3'd2, 32'h20);
        do_write(3'd1, 32'h20);
        src[5] = 1'b1;
        idle(3);
        src[5] = 1'b0;
        idle(4);
        read_expect("edge_pending_held", 3'd0, 32'h20);
        check("edge_irq_high", 32'(irq), 32'h1);
        do_write(3'd0, 32'h20);
        check("edge_irq_after_w1c", 32'(irq), 32'h1);
        cycle();
        check("edge_irq_cleared", 32'(irq), 32'h0);
        src[5] = 1'b1;
        idle(2);
        do_write(3'd0, 32'h20);
        read_expect("edge_set_beats_clear", 3'd0, 32'h20);
        src[5] = 1'b0;

        // Priority between sources 7 and 2
        do_write(3'd2, 32'h0);
        src[7] = 1'b1;
        src[2] = 1'b1;
        do_write(3'd1, 32'h84);
        idle(4);
        read_expect("prio_vec_2", 3'd3, 32'h8000_0002);
        do_write(3'd1, 32'h80);
        read_expect("prio_vec_7", 3'd3, 32'h8000_0007);
        do_write(3'd1, 32'h0);
        read_expect("prio_vec_none", 3'd3, 32'h0);
        check("prio_irq_low", 32'(irq), 32'h0);
        src = '0;
        idle(4);

        // Tick generator
        do_write(3'd4, 32'd4);
        do_write(3'd6, 32'd1);
        for (int k = 1; k <= 12; k++) begin
            cycle();
            check("tick_p4", 32'(tick), (k % 4 == 0) ? 32'h1 : 32'h0);
        end
        do_write(3'd4, 32'd0);
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("tick_p0", 32'(tick), 32'h0);
        end
        do_write(3'd4, 32'd4);
        idle(1);
        do_write(3'd6, 32'd0);
        read_expect("count_frozen_a", 3'd5, 32'd2);
        idle(5);
        read_expect("count_frozen_b", 3'd5, 32'd2);

        // Simultaneous write and read on MASK
        addr = 3'd1; wdata = 32'hFFFF_FFFF; wr = 1'b1; rd = 1'b1;
        cycle();
        wr = 1'b0; rd = 1'b0;
        check("wrrd_ack", 32'(ack), 32'h1);
        check("wrrd_rdata", rdata, 32'h0);
        cycle();
        check("wrrd_single_ack", 32'(ack), 32'h0);
        read_expect("wrrd_mask", 3'd1, 32'h0000_FFFF);

        random_traffic(1500);

        // Reset mid-operation with a read in flight
        addr = 3'd1; rd = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ack", 32'(ack), 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        check("midrst_tick", 32'(tick), 32'h0);
        rd = 1'b0; src = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        read_expect("postrst_pending", 3'd0, 32'h0);
        read_expect("postrst_mask", 3'd1, 32'h0);
        read_expect("postrst_vector", 3'd3, 32'h0);

        random_traffic(1500);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
